// File: rtl/pool_rd_ctrl.sv
// rtl/pool_rd_ctrl.sv - streams pooled channel maps out of BRAM once all channels report pooling done.
// Optional stall counter enabled by defining POOL_RD_STALL_CNT_EN.
module pool_rd_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 14,
   parameter int CH_MAX     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [4:0]            ofmap_size_i,
   input  logic [4:0]            ch_num_i,
   input  logic [15:0]           pool_last_i,
   output logic                  sa_data_rden_o,
   output logic [ADDR_WIDTH-1:0] sa_data_rdptr_o,
   input  logic [DATA_WIDTH-1:0] sa_data_rdata_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  ch_last_o,
   output logic                  frame_last_o,
   output logic                  done_o,
   output logic                  busy_o,
   output logic [15:0]           stall_cnt_o
);

   typedef enum logic [2:0] {IDLE, WAIT_LAST, READ, DRAIN, DONE} state_t;

   state_t                state_q, state_d;
   logic [4:0]            c_q, c_d, ch_q, ch_d;
   logic [9:0]            ss_q, ss_d, word_q, word_d;
   logic [15:0]           mask_q, mask_d, need;
   logic [16:0]           need_full;
   logic                  infl_q, infl_d, infl_cl_q, infl_cl_d, infl_fl_q, infl_fl_d;
   logic [DATA_WIDTH-1:0] fd_q [2];
   logic [DATA_WIDTH-1:0] fd_d [2];
   logic [1:0]            fcl_q, fcl_d, ffl_q, ffl_d, cnt_q, cnt_d;
   logic                  pop, issue, last_word, last_ch, wp;
   logic [2:0]            occ;
   logic [4:0]            c_clamp;

   assign valid_o      = (cnt_q != 2'd0);
   assign data_o       = fd_q[0];
   assign ch_last_o    = valid_o & fcl_q[0];
   assign frame_last_o = valid_o & ffl_q[0];
   assign done_o       = (state_q == DONE);
   assign busy_o       = (state_q != IDLE);

   assign pop       = valid_o & ready_i;
   assign last_word = (word_q == ss_q - 10'd1);
   assign last_ch   = (ch_q == c_q - 5'd1);
   assign need_full = (17'd1 << c_q) - 17'd1;
   assign need      = need_full[15:0];
   assign c_clamp   = (ch_num_i > 5'(CH_MAX)) ? 5'(CH_MAX) : ch_num_i;
   // Occupancy once this cycle settles; a new read may only land if a slot is guaranteed.
   assign occ       = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
   assign issue     = (state_q == READ) && (occ <= 3'd1);

   assign sa_data_rden_o  = issue;
   assign sa_data_rdptr_o = issue ? (ADDR_WIDTH'({ch_q, 10'd0}) + ADDR_WIDTH'(word_q)) : '0;

   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      ch_d      = ch_q;
      ss_d      = ss_q;
      word_d    = word_q;
      mask_d    = mask_q;
      infl_d    = issue;
      infl_cl_d = issue & last_word;
      infl_fl_d = issue & last_word & last_ch;
      fd_d      = fd_q;
      fcl_d     = fcl_q;
      ffl_d     = ffl_q;
      cnt_d     = cnt_q - {1'b0, pop} + {1'b0, infl_q};
      wp        = 1'b0;

      if (pop) begin
         fd_d[0]  = fd_q[1];
         fcl_d[0] = fcl_q[1];
         ffl_d[0] = ffl_q[1];
      end
      if (infl_q) begin
         wp        = cnt_q[0] & ~pop;
         fd_d[wp]  = sa_data_rdata_i;
         fcl_d[wp] = infl_cl_q;
         ffl_d[wp] = infl_fl_q;
      end

      case (state_q)
         IDLE: begin
            if (start_i) begin
               c_d    = c_clamp;
               ss_d   = {5'd0, ofmap_size_i} * {5'd0, ofmap_size_i};
               ch_d   = '0;
               word_d = '0;
               mask_d = '0;
               state_d = (ofmap_size_i == 5'd0 || c_clamp == 5'd0) ? DONE : WAIT_LAST;
            end
         end
         WAIT_LAST: begin
            mask_d = mask_q | pool_last_i;
            if ((mask_d & need) == need) state_d = READ;
         end
         READ: begin
            if (issue) begin
               if (last_word) begin
                  word_d = '0;
                  ch_d   = ch_q + 5'd1;
                  if (last_ch) state_d = DRAIN;
               end else begin
                  word_d = word_q + 10'd1;
               end
            end
         end
         DRAIN: begin
            if (pop && ffl_q[0]) state_d = DONE;
         end
         DONE: begin
            mask_d  = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         c_q       <= '0;
         ch_q      <= '0;
         ss_q      <= '0;
         word_q    <= '0;
         mask_q    <= '0;
         infl_q    <= 1'b0;
         infl_cl_q <= 1'b0;
         infl_fl_q <= 1'b0;
         fd_q[0]   <= '0;
         fd_q[1]   <= '0;
         fcl_q     <= '0;
         ffl_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         c_q       <= c_d;
         ch_q      <= ch_d;
         ss_q      <= ss_d;
         word_q    <= word_d;
         mask_q    <= mask_d;
         infl_q    <= infl_d;
         infl_cl_q <= infl_cl_d;
         infl_fl_q <= infl_fl_d;
         fd_q      <= fd_d;
         fcl_q     <= fcl_d;
         ffl_q     <= ffl_d;
         cnt_q     <= cnt_d;
      end
   end

`ifdef POOL_RD_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (state_q == IDLE && start_i)
         stall_d = '0;
      else if (valid_o && !ready_i && stall_q != 16'hFFFF)
         stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/pool_rd_ctrl.md
POOL_RD_CTRL -- requirements
Module: pool_rd_ctrl

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 8, word width; ADDR_WIDTH, default 14, pooled-data BRAM read address width; CH_MAX, default 16, maximum channel count.
REQ-002 SHALL have ports: clk  input  1  sole clock, all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start_i  input  1  one-cycle pulse, arms a readout frame.
REQ-005 ofmap_size_i  input  5  pooled map side length S, 0..31; sampled on accepted start_i.
REQ-006 ch_num_i  input  5  channel count C, 0..16; sampled on accepted start_i.
REQ-007 pool_last_i  input  16  per-channel "pooling finished" pulses; bit c = channel c.
REQ-008 sa_data_rden_o  output  1  BRAM read enable.
REQ-009 sa_data_rdptr_o  output  ADDR_WIDTH  BRAM read address.
REQ-010 sa_data_rdata_i  input  DATA_WIDTH  BRAM read data, valid exactly 1 cycle after rden.
REQ-011 data_o / valid_o / ready_i  out / out / in  DATA_WIDTH / 1 / 1  output stream, transfer when valid_o & ready_i.
REQ-012 ch_last_o  output  1  qualifies the final word of each channel.
REQ-013 frame_last_o  output  1  qualifies the final word of the final channel.
REQ-014 done_o  output  1  one-cycle pulse, frame complete.
REQ-015 busy_o  output  1  high in any state except IDLE.
REQ-016 stall_cnt_o  output  16  stall counter (see Configuration).

Function
REQ-017 FSM states SHALL be IDLE, WAIT_LAST, READ, DRAIN, DONE.
REQ-018 IDLE -> WAIT_LAST on start_i; start_i outside IDLE SHALL be ignored.
REQ-019 If sampled S==0 or C==0, IDLE -> DONE directly; no reads issued.
REQ-020 WAIT_LAST: OR pool_last_i into sticky 16-bit mask each cycle; -> READ when mask bits [C-1:0] all set (same-cycle pulses count). Pulses in other states ignored.
REQ-021 Address of word k (0..S*S-1) of channel c SHALL be c*1024 + k; channels read in order 0..C-1, words ascending.
REQ-022 Output SHALL use a 2-entry FIFO; a read is issued in a cycle iff fifo_count + inflight - pop <= 1, pop = valid_o & ready_i; sustains 1 word/cycle with ready_i held high.
REQ-023 Stream order SHALL equal read order; no word dropped or duplicated under any ready_i pattern.
REQ-024 data_o/valid_o/ch_last_o/frame_last_o SHALL hold stable while valid_o & ~ready_i.
REQ-025 READ -> DRAIN after the C*S*S-th read issue; DRAIN -> DONE when frame_last word transfers; DONE -> IDLE after one cycle with done_o=1; mask cleared on DONE.
REQ-026 First rden SHALL occur the cycle after entering READ; first valid_o no earlier than 1 cycle after first rden.

Reset
REQ-027 rst SHALL immediately force IDLE and clear mask, counters, FIFO and in-flight flag; BRAM data returning after reset discarded.
REQ-028 All outputs SHALL reset to 0.

Configuration
REQ-029 Macro POOL_RD_STALL_CNT_EN: when defined, stall_cnt_o counts cycles with valid_o & ~ready_i, saturating at 16'hFFFF, cleared on accepted start_i; when undefined, stall_cnt_o tied to 0 and no counter logic exists.

Verification
REQ-030 S=2, C=1, pool_last_i[0] pulse, ready_i=1 -> rdptr 0,1,2,3 on consecutive cycles; 4 words out, ch_last_o and frame_last_o on 4th; done_o one cycle later.
REQ-031 S=3, C=16, pool_last bits arriving scattered over 20 cycles -> no rden until bit 15 seen; 144 words, ch_last_o every 9th, rdptr of channel 5 word 0 = 5120.
REQ-032 S=4, C=2, ready_i random 50% -> 32 words in order matching BRAM model, none lost/duplicated, outputs stable during stall.
REQ-033 S=0 or C=0 with start_i -> no rden, done_o pulse within 2 cycles.
REQ-034 rst asserted mid-READ -> next cycle all outputs 0, state IDLE; new start_i runs a clean frame.
REQ-035 With POOL_RD_STALL_CNT_EN, ready_i low 10 cycles while valid_o high -> stall_cnt_o = 10; without macro -> stall_cnt_o = 0.
